avmm_cfg_arbiter: RTL and testbench

Shares the single Avalon-MM configuration port of the AIB channel register space between N sequencer FSMs (phase adjust, calibration, software CSR bridge). Requests are granted round-robin, one transaction at a time; each granted command is held on the bus until `avmm_waitrequest` releases it, and reads are completed with returned data. A timeout watchdog keeps a stalled slave from hanging every requester.

---
 rtl/aib_cfg_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/avmm_cfg_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_avmm_cfg_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aib_cfg_pkg.sv
// Shared definitions for the AIB channel configuration-space Avalon-MM controllers.
package aib_cfg_pkg;

   localparam int AVMM_ADDR_W = 17;
   localparam int AVMM_DATA_W = 32;
   localparam int AVMM_BE_W   = 4;

   localparam logic [AVMM_DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CMD    = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_gnt_i+1, wrapping modulo N_REQ.
module rr_arbiter #(
   parameter  int N_REQ = 3,
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] last_gnt_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             valid_o
);

   // First requester found after the previous winner takes the grant.
   always_comb begin
      int cand;
      cand    = 0;
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand = (int'(last_gnt_i) + i) % N_REQ;
         if (req_i[cand] && !valid_o) begin
            valid_o     = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = IDX_W'(cand);
         end else begin
            valid_o = valid_o;
         end
      end
   end

endmodule

// File: rtl/avmm_cfg_arbiter.sv
// Round-robin sharing of one Avalon-MM configuration port between N_REQ sequencers,
// one transaction at a time, with a watchdog that aborts stalled commands/reads.
module avmm_cfg_arbiter
   import aib_cfg_pkg::*;
#(
   parameter int N_REQ          = 3,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [N_REQ-1:0]             req_i,
   input  logic [N_REQ-1:0]             req_we_i,
   input  logic [N_REQ*AVMM_ADDR_W-1:0] req_addr_i,
   input  logic [N_REQ*AVMM_DATA_W-1:0] req_wdata_i,
   input  logic [N_REQ*AVMM_BE_W-1:0]   req_be_i,
   output logic [N_REQ-1:0]             gnt_o,
   output logic [N_REQ-1:0]             rsp_valid_o,
   output logic [AVMM_DATA_W-1:0]       rsp_rdata_o,
   output logic                         rsp_err_o,
   output logic [AVMM_ADDR_W-1:0]       avmm_address_out,
   output logic [AVMM_DATA_W-1:0]       avmm_writedata_out,
   output logic [AVMM_BE_W-1:0]         avmm_byteenable_out,
   output logic                         avmm_write_out,
   output logic                         avmm_read_out,
   input  logic                         avmm_waitrequest,
   input  logic [AVMM_DATA_W-1:0]       avmm_readdata,
   input  logic                         avmm_readdatavalid
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

   arb_state_t             state_q, state_d;
   logic [IDX_W-1:0]       last_gnt_q, last_gnt_d;
   logic [IDX_W-1:0]       win_q, win_d;
   logic [N_REQ-1:0]       gnt_q, gnt_d;
   logic [N_REQ-1:0]       rsp_valid_q, rsp_valid_d;
   logic [AVMM_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;
   logic [AVMM_ADDR_W-1:0] addr_q, addr_d;
   logic [AVMM_DATA_W-1:0] wdata_q, wdata_d;
   logic [AVMM_BE_W-1:0]   be_q, be_d;
   logic                   write_q, write_d;
   logic                   read_q, read_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic [N_REQ-1:0]       arb_gnt_s;
   logic [IDX_W-1:0]       arb_idx_s;
   logic                   arb_valid_s;
   logic                   timeout_s;

   rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
      .req_i      (req_i),
      .last_gnt_i (last_gnt_q),
      .gnt_o      (arb_gnt_s),
      .idx_o      (arb_idx_s),
      .valid_o    (arb_valid_s)
   );

   assign timeout_s = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   // Next-state and next-output computation for the transaction sequencer.
   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      win_d       = win_q;
      gnt_d       = gnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      write_d     = write_q;
      read_d      = read_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (arb_valid_s) begin
               state_d = CMD;
               win_d   = arb_idx_s;
               gnt_d   = arb_gnt_s;
               addr_d  = req_addr_i[int'(arb_idx_s)*AVMM_ADDR_W +: AVMM_ADDR_W];
               wdata_d = req_wdata_i[int'(arb_idx_s)*AVMM_DATA_W +: AVMM_DATA_W];
               be_d    = req_be_i[int'(arb_idx_s)*AVMM_BE_W +: AVMM_BE_W];
               write_d = req_we_i[arb_idx_s];
               read_d  = ~req_we_i[arb_idx_s];
               cnt_d   = '0;
            end else begin
               gnt_d = '0;
            end
         end
         CMD: begin
            if (!avmm_waitrequest || timeout_s) begin
               addr_d  = '0;
               wdata_d = '0;
               be_d    = '0;
               write_d = 1'b0;
               read_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            // An accepted command wins over a watchdog expiry in the same cycle.
            if (!avmm_waitrequest) begin
               last_gnt_d = win_q;
               if (write_q) begin
                  state_d     = RESP;
                  rsp_valid_d = gnt_q;
                  rsp_rdata_d = '0;
                  rsp_err_d   = 1'b0;
               end else begin
                  state_d = RDWAIT;
               end
            end else if (timeout_s) begin
               state_d     = RESP;
               rsp_valid_d = gnt_q;
               rsp_rdata_d = TIMEOUT_RDATA;
               rsp_err_d   = 1'b1;
            end else begin
               state_d = CMD;
            end
         end
         RDWAIT: begin
            if (avmm_readdatavalid) begin
               state_d     = RESP;
               rsp_valid_d = gnt_q;
               rsp_rdata_d = avmm_readdata;
               rsp_err_d   = 1'b0;
            end else if (timeout_s) begin
               state_d     = RESP;
               rsp_valid_d = gnt_q;
               rsp_rdata_d = TIMEOUT_RDATA;
               rsp_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d     = IDLE;
            gnt_d       = '0;
            rsp_valid_d = '0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            gnt_d       = '0;
            rsp_valid_d = '0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
            addr_d      = '0;
            wdata_d     = '0;
            be_d        = '0;
            write_d     = 1'b0;
            read_d      = 1'b0;
            cnt_d       = '0;
         end
      endcase
   end

   // State and registered outputs; reset drops the bus command immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_gnt_q  <= LAST_RST;
         win_q       <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         write_q     <= 1'b0;
         read_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         win_q       <= win_d;
         gnt_q       <= gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         write_q     <= write_d;
         read_q      <= read_d;
         cnt_q       <= cnt_d;
      end
   end

   assign gnt_o               = gnt_q;
   assign rsp_valid_o         = rsp_valid_q;
   assign rsp_rdata_o         = rsp_rdata_q;
   assign rsp_err_o           = rsp_err_q;
   assign avmm_address_out    = addr_q;
   assign avmm_writedata_out  = wdata_q;
   assign avmm_byteenable_out = be_q;
   assign avmm_write_out      = write_q;
   assign avmm_read_out       = read_q;

endmodule

// File: tb/tb_avmm_cfg_arbiter.sv
// Directed scoreboard bench for avmm_cfg_arbiter (3 requesters, 16-cycle watchdog).
module tb_avmm_cfg_arbiter;

   logic        clk;
   logic        rst_n;
   logic [2:0]  req;
   logic [2:0]  we;
   logic [50:0] addr;
   logic [95:0] wdata;
   logic [11:0] be;
   logic [2:0]  gnt_o;
   logic [2:0]  rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [16:0] avmm_address_out;
   logic [31:0] avmm_writedata_out;
   logic [3:0]  avmm_byteenable_out;
   logic        avmm_write_out;
   logic        avmm_read_out;
   logic        waitreq;
   logic [31:0] rdata;
   logic        rdv;

   typedef struct {
      logic [2:0]  who;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   lat;

   avmm_cfg_arbiter #(.N_REQ(3), .TIMEOUT_CYCLES(16)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .req_i               (req),
      .req_we_i            (we),
      .req_addr_i          (addr),
      .req_wdata_i         (wdata),
      .req_be_i            (be),
      .gnt_o               (gnt_o),
      .rsp_valid_o         (rsp_valid_o),
      .rsp_rdata_o         (rsp_rdata_o),
      .rsp_err_o           (rsp_err_o),
      .avmm_address_out    (avmm_address_out),
      .avmm_writedata_out  (avmm_writedata_out),
      .avmm_byteenable_out (avmm_byteenable_out),
      .avmm_write_out      (avmm_write_out),
      .avmm_read_out       (avmm_read_out),
      .avmm_waitrequest    (waitreq),
      .avmm_readdata       (rdata),
      .avmm_readdatavalid  (rdv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [2:0] who, input logic [31:0] d, input logic err);
      exp_t e;
      e.who   = who;
      e.rdata = d;
      e.err   = err;
      sb_q.push_back(e);
   endtask

   task automatic apply(input int i, input logic w, input logic [16:0] a,
                        input logic [31:0] d, input logic [3:0] b);
      req[i]          = 1'b1;
      we[i]           = w;
      addr[i*17 +: 17] = a;
      wdata[i*32 +: 32] = d;
      be[i*4 +: 4]    = b;
   endtask

   task automatic drop(input int i);
      req[i] = 1'b0;
   endtask

   // Step until a response pulse (bounded), then compare it against the scoreboard head.
   task automatic wait_rsp(input string tag, input int budget, output int n);
      exp_t e;
      n = 0;
      do begin
         step();
         n++;
      end while (rsp_valid_o == 3'b000 && n < budget);
      n_checks++;
      assert (rsp_valid_o !== 3'b000) else begin
         n_errors++;
         $error("FAIL %s_rsp observed=none expected=pulse within %0d cycles", tag, budget);
      end
      if (rsp_valid_o !== 3'b000) begin
         chk({tag, "_sb_nonempty"}, 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_who"},   64'(rsp_valid_o), 64'(e.who));
            chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
            chk({tag, "_err"},   64'(rsp_err_o),   64'(e.err));
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; be = '0;
      waitreq = 1'b0; rdata = '0; rdv = 1'b0;
      repeat (3) step();
      chk("rst_gnt",   64'(gnt_o), 64'd0);
      chk("rst_rspv",  64'(rsp_valid_o), 64'd0);
      chk("rst_rdata", 64'(rsp_rdata_o), 64'd0);
      chk("rst_err",   64'(rsp_err_o), 64'd0);
      chk("rst_cmd",   64'({avmm_write_out, avmm_read_out}), 64'd0);
      chk("rst_bus",   64'({avmm_address_out, avmm_writedata_out, avmm_byteenable_out}), 64'd0);
      rst_n = 1'b1;
      step();

      // Single zero-wait write from requester 1.
      apply(1, 1'b1, 17'h0133C, 32'h4000_0000, 4'hF);
      push_exp(3'b010, 32'h0, 1'b0);
      step();
      chk("t1_gnt",   64'(gnt_o), 64'h2);
      chk("t1_cmd",   64'({avmm_write_out, avmm_read_out}), 64'h2);
      chk("t1_addr",  64'(avmm_address_out), 64'h0133C);
      chk("t1_wdata", 64'(avmm_writedata_out), 64'h4000_0000);
      chk("t1_be",    64'(avmm_byteenable_out), 64'hF);
      wait_rsp("t1", 8, lat);
      chk("t1_lat", 64'(lat), 64'd1);
      chk("t1_cmd_drop", 64'({avmm_write_out, avmm_address_out}), 64'd0);
      step();
      drop(1);
      chk("t1_gnt_drop", 64'(gnt_o), 64'd0);

      // Read from requester 0: three wait cycles, data two cycles after accept.
      waitreq = 1'b1;
      apply(0, 1'b0, 17'h00010, 32'h0, 4'hF);
      push_exp(3'b001, 32'h0800_0A00, 1'b0);
      step();
      chk("t2_read", 64'({avmm_write_out, avmm_read_out}), 64'h1);
      chk("t2_gnt",  64'(gnt_o), 64'h1);
      step();
      step();
      chk("t2_read_held", 64'(avmm_read_out), 64'd1);
      step();
      waitreq = 1'b0;
      step();
      chk("t2_read_drop", 64'(avmm_read_out), 64'd0);
      step();
      rdv = 1'b1;
      rdata = 32'h0800_0A00;
      chk("t2_early", 64'(rsp_valid_o), 64'd0);
      wait_rsp("t2", 1, lat);
      rdv = 1'b0;
      step();
      drop(0);

      // Fresh reset, then all three requesters held continuously.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      for (int i = 0; i < 3; i++) apply(i, 1'b1, 17'(32'h100 + i), 32'hA5A5_0000 + i, 4'h3);
      for (int k = 0; k < 6; k++) push_exp(3'(1 << (k % 3)), 32'h0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         wait_rsp("t3", 8, lat);
         chk("t3_lat", 64'(lat), (k == 0) ? 64'd2 : 64'd3);
      end
      step();
      req = '0;

      // Read that never returns data: watchdog fires 16 cycles after RDWAIT entry.
      apply(2, 1'b0, 17'h10200, 32'h0, 4'hF);
      push_exp(3'b100, 32'hDEAD_BEEF, 1'b1);
      step();
      step();
      repeat (15) step();
      chk("t4_early", 64'(rsp_valid_o), 64'd0);
      wait_rsp("t4", 1, lat);
      step();
      drop(2);
      rdv = 1'b1;
      rdata = 32'h1234_5678;
      step();
      rdv = 1'b0;
      chk("t4_spur_rsp", 64'(rsp_valid_o), 64'd0);
      chk("t4_spur_gnt", 64'(gnt_o), 64'd0);
      apply(1, 1'b0, 17'h00044, 32'h0, 4'hF);
      push_exp(3'b010, 32'hCAFE_0001, 1'b0);
      step();
      step();
      rdv = 1'b1;
      rdata = 32'hCAFE_0001;
      wait_rsp("t4b", 1, lat);
      rdv = 1'b0;
      step();
      drop(1);

      // Reset while a command is stalled on waitrequest.
      waitreq = 1'b1;
      apply(1, 1'b1, 17'h00999, 32'h1111_2222, 4'hF);
      step();
      chk("t5_write", 64'(avmm_write_out), 64'd1);
      chk("t5_gnt",   64'(gnt_o), 64'h2);
      apply(0, 1'b1, 17'h00001, 32'h3333_4444, 4'hF);
      apply(2, 1'b1, 17'h00002, 32'h5555_6666, 4'hF);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_async_cmd",  64'({avmm_write_out, avmm_read_out}), 64'd0);
      chk("t5_async_gnt",  64'(gnt_o), 64'd0);
      chk("t5_async_addr", 64'(avmm_address_out), 64'd0);
      step();
      step();
      chk("t5_no_rsp", 64'(rsp_valid_o), 64'd0);
      waitreq = 1'b0;
      rst_n = 1'b1;
      push_exp(3'b001, 32'h0, 1'b0);
      step();
      chk("t5_first_gnt", 64'(gnt_o), 64'h1);
      wait_rsp("t5", 4, lat);
      step();
      req = '0;
      step();

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
